// File: rtl/spi_gpio_pkg.sv
// Shared constants and types for the SPI-slave GPIO expander: register map bases,
// frame geometry and the frame state machine encoding.
package spi_gpio_pkg;

  localparam int FRAME_BITS = 16;
  localparam int CMD_BITS   = 8;

  localparam logic [6:0] ADDR_OUT  = 7'h00;
  localparam logic [6:0] ADDR_DIR  = 7'h08;
  localparam logic [6:0] ADDR_IN   = 7'h10;
  localparam logic [6:0] ADDR_SET  = 7'h18;
  localparam logic [6:0] ADDR_CLR  = 7'h20;
  localparam logic [6:0] ADDR_IEN  = 7'h28;
  localparam logic [6:0] ADDR_STAT = 7'h30;
  localparam logic [6:0] ADDR_RAM  = 7'h40;
  localparam logic [6:0] ADDR_ID   = 7'h7F;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } spi_state_e;

endpackage

// File: rtl/spi_gpio_ctrl_if.sv
// SPI pin bundle between a bus master and the GPIO expander (mode 0, active-low select).
interface spi_gpio_ctrl_if;
  logic spi_sclk;
  logic spi_cs_n;
  logic spi_mosi;
  logic spi_miso;

  modport master (output spi_sclk, output spi_cs_n, output spi_mosi, input spi_miso);
  modport slave  (input spi_sclk, input spi_cs_n, input spi_mosi, output spi_miso);
endinterface

// File: rtl/spi_gpio_sync.sv
// Width-parametrised flop chain bringing asynchronous pins into the clk domain.
module spi_gpio_sync
  import spi_gpio_pkg::*;
#(
  parameter int               WIDTH   = 1,
  parameter int               STAGES  = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain_q [STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) chain_q[i] <= RST_VAL;
    end else begin
      chain_q[0] <= d;
      for (int i = 1; i < STAGES; i++) chain_q[i] <= chain_q[i-1];
    end
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/spi_gpio_ctrl.sv
// SPI-slave GPIO expander running entirely on clk with oversampled SPI pins.
// Optional interrupt block (IEN/STAT registers, irq port) enabled by SPI_GPIO_IRQ_EN.
//
// state | meaning
// IDLE  | waiting for cs_n falling edge, miso held 0
// CMD   | shifting rw + address, decode on the 8th rising edge
// DATA  | shifting data in / read data out, write request on 16th rising edge
// DONE  | frame complete, SCLK ignored until cs_n rises
module spi_gpio_ctrl
  import spi_gpio_pkg::*;
#(
  parameter int N_GPIO      = 16,
  parameter int RAM_DEPTH   = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  spi_gpio_ctrl_if.slave    spi,
  input  logic [N_GPIO-1:0] gpio_in,
  output logic [N_GPIO-1:0] gpio_out,
  output logic [N_GPIO-1:0] gpio_oe
`ifdef SPI_GPIO_IRQ_EN
  ,
  output logic              irq
`endif
);

  localparam int N_BANKS = (N_GPIO + 7) / 8;
  localparam int RAM_AW  = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

  logic [2:0]        spi_s;
  logic              sclk_s, cs_s, mosi_s;
  logic              sclk_d, cs_d;
  logic              sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [N_GPIO-1:0] gpio_s;

  spi_gpio_sync #(.WIDTH(3), .STAGES(SYNC_STAGES), .RST_VAL(3'b010)) u_sync_spi (
    .clk (clk),
    .rst (rst),
    .d   ({spi.spi_sclk, spi.spi_cs_n, spi.spi_mosi}),
    .q   (spi_s)
  );

  spi_gpio_sync #(.WIDTH(N_GPIO), .STAGES(SYNC_STAGES)) u_sync_gpio (
    .clk (clk),
    .rst (rst),
    .d   (gpio_in),
    .q   (gpio_s)
  );

  assign {sclk_s, cs_s, mosi_s} = spi_s;
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_rise   = cs_s & ~cs_d;
  assign cs_fall   = ~cs_s & cs_d;

  spi_state_e        state_q, state_nx;
  logic [4:0]        bit_cnt_q;
  logic [6:0]        rx_shift_q;
  logic [7:0]        shift_byte;
  logic              rw_q;
  logic [6:0]        addr_q;
  logic [7:0]        tx_shift_q;
  logic              tx_live_q;
  logic              miso_q;
  logic              wr_pend_q;
  logic [6:0]        wr_addr_q;
  logic [7:0]        wr_data_q;
  logic              clr_cnt, shift_en, decode, commit, tx_fall;
  logic [7:0]        rd_data;

  // Byte completed by the current rising edge: command at decode, data at commit.
  assign shift_byte = {rx_shift_q, mosi_s};

  // SCLK edges only matter in CMD/DATA; a cs_n rise in the same cycle as the
  // 16th edge still lets the commit through.
  always_comb begin
    state_nx = state_q;
    clr_cnt  = 1'b0;
    shift_en = 1'b0;
    decode   = 1'b0;
    commit   = 1'b0;
    tx_fall  = 1'b0;
    case (state_q)
      IDLE: if (cs_fall) begin
        state_nx = CMD;
        clr_cnt  = 1'b1;
      end
      CMD: if (sclk_rise) begin
        shift_en = 1'b1;
        if (bit_cnt_q == 5'(CMD_BITS - 1)) begin
          decode   = 1'b1;
          state_nx = DATA;
        end
      end
      DATA: begin
        tx_fall = sclk_fall;
        if (sclk_rise) begin
          shift_en = 1'b1;
          if (bit_cnt_q == 5'(FRAME_BITS - 1)) begin
            commit   = 1'b1;
            state_nx = DONE;
          end
        end
      end
      DONE: ;
      default: state_nx = IDLE;
    endcase
    if (cs_rise) state_nx = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sclk_d     <= 1'b0;
      cs_d       <= 1'b1;
      bit_cnt_q  <= '0;
      rx_shift_q <= '0;
      rw_q       <= 1'b0;
      addr_q     <= '0;
      tx_shift_q <= '0;
      tx_live_q  <= 1'b0;
      miso_q     <= 1'b0;
      wr_pend_q  <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q <= state_nx;
      sclk_d  <= sclk_s;
      cs_d    <= cs_s;
      if (clr_cnt) bit_cnt_q <= '0;
      else if (shift_en) bit_cnt_q <= bit_cnt_q + 5'd1;
      if (shift_en) rx_shift_q <= shift_byte[6:0];
      if (decode) begin
        rw_q       <= shift_byte[7];
        addr_q     <= shift_byte[6:0];
        tx_shift_q <= shift_byte[7] ? rd_data : 8'h00;
        tx_live_q  <= 1'b0;
      end
      if (cs_rise || state_q == IDLE || state_q == CMD) begin
        miso_q <= 1'b0;
      end else if (tx_fall) begin
        if (!tx_live_q) begin
          miso_q    <= tx_shift_q[7];
          tx_live_q <= 1'b1;
        end else begin
          miso_q     <= tx_shift_q[6];
          tx_shift_q <= {tx_shift_q[6:0], 1'b0};
        end
      end
      wr_pend_q <= commit & ~rw_q;
      if (commit) begin
        wr_addr_q <= addr_q;
        wr_data_q <= shift_byte;
      end
    end
  end

  assign spi.spi_miso = miso_q;

  logic [N_GPIO-1:0] out_q, dir_q;
  logic [7:0]        ram_q [RAM_DEPTH];
  logic [63:0]       out_pad, dir_pad, in_pad;
  logic [6:0]        rd_addr;
  logic [5:0]        rd_off, wr_off;
  logic [6:0]        wr_region;
  logic              wr_bank_ok, wr_ram_ok;
  logic [N_GPIO-1:0] wr_bits, wr_mask;

  assign out_pad = 64'(out_q);
  assign dir_pad = 64'(dir_q);
  assign in_pad  = 64'(gpio_s);
  assign rd_addr = shift_byte[6:0];
  assign rd_off  = {rd_addr[2:0], 3'b000};

  assign wr_off     = {wr_addr_q[2:0], 3'b000};
  assign wr_region  = {wr_addr_q[6:3], 3'b000};
  assign wr_bank_ok = wr_pend_q && !wr_addr_q[6] && (int'(wr_addr_q[2:0]) < N_BANKS);
  assign wr_ram_ok  = wr_pend_q && wr_addr_q[6] && (wr_addr_q != ADDR_ID)
                      && (int'(wr_addr_q[5:0]) < RAM_DEPTH);
  // Bits beyond N_GPIO fall off here, so partial last banks ignore them.
  assign wr_bits    = N_GPIO'(64'(wr_data_q) << wr_off);
  assign wr_mask    = N_GPIO'(64'hFF << wr_off);

`ifdef SPI_GPIO_IRQ_EN
  logic [N_GPIO-1:0] ien_q, stat_q, gin_d;
  logic              irq_q;
  logic [63:0]       ien_pad, stat_pad;

  assign ien_pad  = 64'(ien_q);
  assign stat_pad = 64'(stat_q);
`endif

  always_comb begin
    rd_data = 8'h00;
    if (rd_addr[6]) begin
      if (rd_addr == ADDR_ID) rd_data = 8'(N_GPIO);
      else if (int'(rd_addr[5:0]) < RAM_DEPTH) rd_data = ram_q[rd_addr[RAM_AW-1:0]];
    end else if (int'(rd_addr[2:0]) < N_BANKS) begin
      case ({rd_addr[6:3], 3'b000})
        ADDR_OUT, ADDR_SET, ADDR_CLR: rd_data = out_pad[rd_off +: 8];
        ADDR_DIR:  rd_data = dir_pad[rd_off +: 8];
        ADDR_IN:   rd_data = in_pad[rd_off +: 8];
`ifdef SPI_GPIO_IRQ_EN
        ADDR_IEN:  rd_data = ien_pad[rd_off +: 8];
        ADDR_STAT: rd_data = stat_pad[rd_off +: 8];
`endif
        default:   rd_data = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
      dir_q <= '0;
      for (int k = 0; k < RAM_DEPTH; k++) ram_q[k] <= 8'h00;
    end else begin
      if (wr_bank_ok && wr_region == ADDR_OUT) out_q <= (out_q & ~wr_mask) | wr_bits;
      if (wr_bank_ok && wr_region == ADDR_SET) out_q <= out_q | wr_bits;
      if (wr_bank_ok && wr_region == ADDR_CLR) out_q <= out_q & ~wr_bits;
      if (wr_bank_ok && wr_region == ADDR_DIR) dir_q <= (dir_q & ~wr_mask) | wr_bits;
      if (wr_ram_ok) ram_q[wr_addr_q[RAM_AW-1:0]] <= wr_data_q;
    end
  end

  assign gpio_out = out_q;
  assign gpio_oe  = dir_q;

`ifdef SPI_GPIO_IRQ_EN
  // A new rising edge wins over a W1C of the same bit in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ien_q  <= '0;
      stat_q <= '0;
      gin_d  <= '0;
      irq_q  <= 1'b0;
    end else begin
      gin_d <= gpio_s;
      if (wr_bank_ok && wr_region == ADDR_IEN) ien_q <= (ien_q & ~wr_mask) | wr_bits;
      stat_q <= (stat_q & ~((wr_bank_ok && wr_region == ADDR_STAT) ? wr_bits : '0))
                | (gpio_s & ~gin_d & ien_q);
      irq_q  <= |stat_q;
    end
  end

  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_spi_gpio_ctrl.sv
// Directed bench for spi_gpio_ctrl: a 16-pin and a 10-pin instance share the
// same SPI stimulus and are checked against a register-map model.
module tb_spi_gpio_ctrl;

  localparam int HALF = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_gpio_ctrl_if if_a ();
  spi_gpio_ctrl_if if_b ();

  logic [15:0] gin_a, gout_a, goe_a;
  logic [9:0]  gin_b, gout_b, goe_b;
`ifdef SPI_GPIO_IRQ_EN
  logic irq_a, irq_b;
`endif

  spi_gpio_ctrl #(.N_GPIO(16)) dut_a (
    .clk (clk), .rst (rst), .spi (if_a.slave),
    .gpio_in (gin_a), .gpio_out (gout_a), .gpio_oe (goe_a)
`ifdef SPI_GPIO_IRQ_EN
    , .irq (irq_a)
`endif
  );

  spi_gpio_ctrl #(.N_GPIO(10)) dut_b (
    .clk (clk), .rst (rst), .spi (if_b.slave),
    .gpio_in (gin_b), .gpio_out (gout_b), .gpio_oe (goe_b)
`ifdef SPI_GPIO_IRQ_EN
    , .irq (irq_b)
`endif
  );

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Model state per instance: index 0 = 16 pins, index 1 = 10 pins.
  int          ngp [2] = '{16, 10};
  logic [63:0] out_m [2];
  logic [63:0] dir_m [2];
  logic [7:0]  ram_m [2][4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_read(input int i, input logic [6:0] a, input logic [63:0] gin);
    int n, b, base, p;
    logic [7:0] r;
    n = ngp[i];
    b = int'(a) % 8;
    base = int'(a) - b;
    r = 8'h00;
    if (a == 7'h7F) return 8'(n);
    if (int'(a) >= 'h40) return (int'(a) - 'h40 < 4) ? ram_m[i][int'(a) - 'h40] : 8'h00;
    for (int j = 0; j < 8; j++) begin
      p = b * 8 + j;
      if (p < n) begin
        if (base == 'h00 || base == 'h18 || base == 'h20) r[j] = out_m[i][p];
        else if (base == 'h08) r[j] = dir_m[i][p];
        else if (base == 'h10) r[j] = gin[p];
      end
    end
    return r;
  endfunction

  task automatic model_write(input int i, input logic [6:0] a, input logic [7:0] d);
    int n, b, base, p;
    n = ngp[i];
    b = int'(a) % 8;
    base = int'(a) - b;
    if (int'(a) >= 'h40) begin
      if (a != 7'h7F && int'(a) - 'h40 < 4) ram_m[i][int'(a) - 'h40] = d;
    end else begin
      for (int j = 0; j < 8; j++) begin
        p = b * 8 + j;
        if (p < n) begin
          if (base == 'h00) out_m[i][p] = d[j];
          else if (base == 'h08) dir_m[i][p] = d[j];
          else if (base == 'h18 && d[j]) out_m[i][p] = 1'b1;
          else if (base == 'h20 && d[j]) out_m[i][p] = 1'b0;
        end
      end
    end
  endtask

  task automatic drive(input logic sclk, input logic cs_n, input logic mosi);
    if_a.spi_sclk = sclk; if_a.spi_cs_n = cs_n; if_a.spi_mosi = mosi;
    if_b.spi_sclk = sclk; if_b.spi_cs_n = cs_n; if_b.spi_mosi = mosi;
  endtask

  // Bit-bang a mode-0 frame; MISO is captured on each master rising edge of bits 8..15.
  task automatic frame(input logic [15:0] w, input int nbits, input bit cs_with_last,
                       output logic [7:0] ra, output logic [7:0] rb);
    logic cs;
    ra = 8'h00;
    rb = 8'h00;
    cs = 1'b0;
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0);
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      drive(1'b0, cs, w[15-i]);
      repeat (HALF) @(negedge clk);
      if (cs_with_last && i == nbits - 1) cs = 1'b1;
      drive(1'b1, cs, w[15-i]);
      if (i >= 8) begin
        ra = {ra[6:0], if_a.spi_miso};
        rb = {rb[6:0], if_b.spi_miso};
      end
      repeat (HALF) @(negedge clk);
      drive(1'b0, cs, w[15-i]);
    end
    if (!cs_with_last) begin
      repeat (HALF) @(negedge clk);
      drive(1'b0, 1'b1, 1'b0);
    end
    repeat (12) @(negedge clk);
  endtask

  task automatic xfer(input logic [15:0] w, input int nbits, input bit late,
                      output logic [7:0] ra, output logic [7:0] rb);
    logic [7:0] ea, eb;
    chk_en = 1'b0;
    ea = model_read(0, w[14:8], 64'(gin_a));
    eb = model_read(1, w[14:8], 64'(gin_b));
    frame(w, nbits, late, ra, rb);
    if (nbits == 16 && w[15]) begin
      check($sformatf("rd16_%04h", w), 64'(ra), 64'(ea));
      check($sformatf("rd10_%04h", w), 64'(rb), 64'(eb));
    end
    if (nbits == 16 && !w[15]) begin
      model_write(0, w[14:8], w[7:0]);
      model_write(1, w[14:8], w[7:0]);
    end
    chk_en = 1'b1;
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("pins16_out", 64'(gout_a), 64'(out_m[0][15:0]));
      check("pins16_oe",  64'(goe_a),  64'(dir_m[0][15:0]));
      check("pins10_out", 64'(gout_b), 64'(out_m[1][9:0]));
      check("pins10_oe",  64'(goe_b),  64'(dir_m[1][9:0]));
      check("miso_idle",  64'({if_a.spi_miso, if_b.spi_miso}), 64'(0));
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ra, rb;
    rst = 1'b1;
    gin_a = '0;
    gin_b = '0;
    drive(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      out_m[i] = '0;
      dir_m[i] = '0;
      for (int k = 0; k < 4; k++) ram_m[i][k] = 8'h00;
    end
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_out16", 64'(gout_a), 64'(0));
    check("rst_oe16",  64'(goe_a),  64'(0));
    check("rst_out10", 64'(gout_b), 64'(0));
    check("rst_miso",  64'({if_a.spi_miso, if_b.spi_miso}), 64'(0));
    chk_en = 1'b1;

    xfer(16'h0055, 16, 1'b0, ra, rb);
    check("out_55", 64'(gout_a[7:0]), 64'h55);
    check("oe_0",   64'(goe_a), 64'h0);
    xfer(16'h08FF, 16, 1'b0, ra, rb);
    check("oe_ff",  64'(goe_a[7:0]), 64'hFF);
    xfer(16'h180A, 16, 1'b0, ra, rb);
    check("set_5f", 64'(gout_a[7:0]), 64'h5F);
    xfer(16'h2003, 16, 1'b0, ra, rb);
    check("clr_5c", 64'(gout_a[7:0]), 64'h5C);

    gin_a = 16'hA5C3;
    gin_b = 10'h3C3;
    repeat (6) @(negedge clk);
    xfer(16'h9100, 16, 1'b0, ra, rb);
    check("in_a5", 64'(ra), 64'hA5);
    check("in_03", 64'(rb), 64'h03);
    xfer(16'hFF00, 16, 1'b0, ra, rb);
    check("id_16", 64'(ra), 64'h10);
    check("id_10", 64'(rb), 64'h0A);

    xfer(16'h4233, 16, 1'b0, ra, rb);
    xfer(16'hC200, 16, 1'b0, ra, rb);
    check("ram_33", 64'(ra), 64'h33);
    xfer(16'hE000, 16, 1'b0, ra, rb);
    check("unmapped", 64'(ra), 64'h00);

    xfer(16'h00FF, 12, 1'b0, ra, rb);
    check("abort_out", 64'(gout_a[7:0]), 64'h5C);
    xfer(16'h0011, 16, 1'b0, ra, rb);
    check("after_abort", 64'(gout_a[7:0]), 64'h11);

    xfer(16'h01FF, 16, 1'b0, ra, rb);
    check("n10_hi", 64'(gout_b[9:8]), 64'h3);
    xfer(16'h8100, 16, 1'b0, ra, rb);
    check("n10_rd", 64'(rb), 64'h03);
    check("n16_rd", 64'(ra), 64'hFF);

    xfer(16'h0244, 16, 1'b0, ra, rb);
    xfer(16'h8200, 16, 1'b0, ra, rb);
    xfer(16'h1077, 16, 1'b0, ra, rb);
    xfer(16'h7F33, 16, 1'b0, ra, rb);
    xfer(16'h8800, 16, 1'b0, ra, rb);
    check("dir_rd", 64'(ra), 64'hFF);

    xfer(16'h00A0, 16, 1'b1, ra, rb);
    check("late_cs", 64'(gout_a[7:0]), 64'hA0);
    xfer(16'h8000, 16, 1'b0, ra, rb);

`ifdef SPI_GPIO_IRQ_EN
    gin_a = '0;
    gin_b = '0;
    repeat (8) @(negedge clk);
    xfer(16'h2801, 16, 1'b0, ra, rb);
    check("irq_idle", 64'({irq_a, irq_b}), 64'h0);
    gin_a[0] = 1'b1;
    gin_b[0] = 1'b1;
    repeat (8) @(negedge clk);
    check("irq_set", 64'({irq_a, irq_b}), 64'h3);
    xfer(16'h3001, 16, 1'b0, ra, rb);
    check("irq_clr", 64'({irq_a, irq_b}), 64'h0);
`endif

    chk_en = 1'b0;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_gpio_ctrl.md
Name: spi_gpio_ctrl

Overview:
- Parametrised SPI-slave GPIO expander; successor to the fixed 10-pin shift-register GPIO.
- Runs entirely on the system clock: SPI pins are oversampled through synchronisers, so there is no clocking from SCLK.
- Adds N-pin banks, direction control, atomic set/clear, synchronised inputs, a scratch RAM, same-frame read data and explicit frame abort.

Parameters:
- N_GPIO, 16, number of GPIO pins; legal 1..64; banks of 8, N_BANKS = ceil(N_GPIO/8) as a localparam.
- RAM_DEPTH, 4, scratch bytes; legal 1..16.
- SYNC_STAGES, 2, flops in every input synchroniser; legal 2..4.

Ports:
- clk  in  1  system clock; SCLK frequency must be at most clk/4.
- rst  in  1  synchronous, active-high reset.
- spi_sclk  in  1  SPI clock, mode 0.
- spi_cs_n  in  1  chip select, active low.
- spi_mosi  in  1  serial data in, MSB first.
- spi_miso  out  1  serial data out.
- gpio_in  in  N_GPIO  pin inputs (asynchronous).
- gpio_out  out  N_GPIO  pin output values.
- gpio_oe  out  N_GPIO  output enables; 1 = drive.

Behaviour:
- Reset: synchronous and active-high; rst wins over any other event in the same cycle. After rst:
  - state IDLE;
  - OUT, DIR and RAM cleared to 0;
  - gpio_out = 0, gpio_oe = 0, spi_miso = 0;
  - bit counter = 0.
- Input sampling: spi_sclk, spi_cs_n, spi_mosi and gpio_in each pass through SYNC_STAGES flops. Edge detection compares the last synchronised sample with the one before it. All SPI decisions below use the synchronised signals.
- Frame format, 16 bits: bit15 rw (1 = read), bits14:8 addr, bits7:0 data.
  - MOSI is sampled on detected SCLK rising edges.
  - MISO changes on detected SCLK falling edges.
- State machine:
  - IDLE -> CMD on a cs_n falling edge; bit counter = 0.
  - CMD: shift in 8 bits. On the 8th rising edge, decode the address; if rw=1, load rd_data into tx_shift. Then go to DATA.
  - DATA: spi_miso presents tx_shift[7] from the 8th falling edge and shifts on each following falling edge.
    - On the 16th rising edge, a write commits on the next clk: target register updated, gpio_out/gpio_oe updated in the same cycle.
    - Then go to DONE.
  - DONE: all further SCLK edges are ignored until cs_n rises.
  - Any state: a cs_n rising edge returns to IDLE and drives spi_miso = 0.
    - Rising before the 16th bit: frame aborted, nothing written.
    - 16th rising edge and cs_n rising detected in the same cycle: the write still commits.
- spi_miso is 0 in IDLE and during CMD. SCLK edges while cs_n is high are ignored.
- Register map, b = bank index (0..N_BANKS-1):
  - 0x00+b OUT (R/W).
  - 0x08+b DIR (R/W; 1 = output).
  - 0x10+b IN (RO; synchronised gpio_in).
  - 0x18+b SET (W1S into OUT; reads return OUT).
  - 0x20+b CLR (W1C into OUT; reads return OUT).
  - 0x40+k RAM[k] (R/W).
  - 0x7F ID (RO; returns N_GPIO).
- Pin outputs: gpio_out = OUT bits; gpio_oe = DIR bits.
- Out-of-range accesses: bits at or above N_GPIO in the last bank read 0 and ignore writes. Unmapped addresses and banks at or beyond N_BANKS read 0x00 and ignore writes. Writes to RO addresses are ignored.
- Latency: a pin edge propagates to a visible gpio_out change in SYNC_STAGES+2 clk. An IN read returns the sample taken at the 8th-rising-edge decode.

Optional Feature:
- Macro: SPI_GPIO_IRQ_EN.
- Defined:
  - adds output port irq (1 bit);
  - adds IEN registers 0x28+b (R/W) and STAT registers 0x30+b (read; W1C);
  - a rising edge on a synchronised input whose IEN bit is set sets its STAT bit; a set in the same cycle as a W1C clear of that bit takes priority;
  - irq = registered OR of all STAT bits, 1-cycle latency;
  - reset clears IEN, STAT and irq.
- Undefined: no irq port; 0x28-0x37 are unmapped.

Decomposition:
- spi_gpio_pkg holds:
  - address base constants (ADDR_OUT, ADDR_DIR, ADDR_IN, ADDR_SET, ADDR_CLR, ADDR_IEN, ADDR_STAT, ADDR_RAM, ADDR_ID);
  - FRAME_BITS = 16, CMD_BITS = 8;
  - the state enum (IDLE, CMD, DATA, DONE).
- One sub-module: spi_gpio_sync, a width-parametrised SYNC_STAGES flop chain, instantiated for the SPI pins and for gpio_in.

Test Plan:
- Reset, then write frame 0x0055 -> gpio_out[7:0] = 0x55, gpio_oe = 0. Write 0x08FF -> gpio_oe[7:0] = 0xFF.
- OUT bank0 = 0x55, then write SET 0x180A -> OUT = 0x5F. Then write CLR 0x2003 -> OUT = 0x5C.
- gpio_in = 0xA5C3, read 0x9100 -> MISO data byte = 0xA5, driven in the same frame. Read 0xFF00 -> 0x10.
- Write RAM 0x4233, then read 0xC200 -> 0x33. Read unmapped 0xE000 -> 0x00.
- Raise cs_n after 12 bits of 0x00FF -> OUT unchanged, state back to IDLE. A following full frame works normally.
- N_GPIO=10: write 0x01FF -> gpio_out[9:8] = 2'b11; read back 0x8100 -> 0x03. With SPI_GPIO_IRQ_EN: IEN0 = 0x01 and gpio_in[0] rising -> irq = 1; write 0x3001 -> irq = 0.
